hsem_lock: RTL and testbench
============================

HSEM_LOCK -- requirements
Module: hsem_lock

Interface
REQ-001 SHALL have parameter: NSEM, 8, number of semaphores (legal 1..16).
REQ-002 SHALL have port: hclk  input  1  clock, all state on rising edge.
REQ-003 SHALL have port: hresetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: req_valid_0 / req_valid_1  input  1  per-core request strobe, one cycle per request.
REQ-005 SHALL have ports: req_op_0 / req_op_1  input  1  1 = lock, 0 = unlock.
REQ-006 SHALL have ports: req_id_0 / req_id_1  input  4  semaphore index.
REQ-007 SHALL have ports: grant_0 / grant_1  output  1  one-cycle pulse when the core becomes owner.
REQ-008 SHALL have ports: pending_0 / pending_1  output  1  level, core is queued on some semaphore.
REQ-009 SHALL have ports: semerr_0 / semerr_1  output  32  one-cycle error-code pulse, feeds the HSEM interrupt/error block.
REQ-010 SHALL have ports: owned_0 / owned_1  output  NSEM  per-semaphore ownership bitmap.

Function
REQ-011 SHALL keep one state per semaphore: FREE, OWN0, OWN1, OWN0_W1 (core 0 owns, core 1 queued), OWN1_W0.
REQ-012 SHALL register every output; response appears one cycle after the request cycle.
REQ-013 Lock on FREE SHALL go to OWNx and pulse grant_x.
REQ-014 Lock on a semaphore owned by the other core with no waiter SHALL go to OWNy_Wx, set pending_x, no grant.
REQ-015 Unlock by the owner with no waiter SHALL go to FREE.
REQ-016 Unlock by the owner with a waiter SHALL hand off (OWN0_W1 -> OWN1, OWN1_W0 -> OWN0), pulse the waiter's grant, clear its pending.
REQ-017 Unlock by the queued waiter SHALL cancel the wait (OWNy_Wx -> OWNy), clear pending_x, no error.
REQ-018 Error codes: bit0 = unlock by non-owner/non-waiter; bit1 = lock by current owner or by already-queued core; bit2 = unlock of FREE; bit3 = req_id >= NSEM. Other bits 0.
REQ-019 Errored requests SHALL leave all state unchanged; semerr_x carries exactly one code bit for exactly one cycle.
REQ-020 Lock while pending on a different semaphore SHALL raise bit1 and be ignored (one outstanding wait per core).
REQ-021 Both cores locking the same FREE semaphore in one cycle: core 0 wins (OWN0_W1), grant_0 = 1, pending_1 = 1.
REQ-022 Same semaphore, same cycle, both requests valid: core 0's request SHALL be applied first, then core 1's against the updated state. Example: OWN0 + unlock_0 + lock_1 -> OWN1, grant_1.
REQ-023 Requests to different semaphores in the same cycle SHALL be processed independently.
REQ-024 req_op/req_id SHALL be ignored when req_valid is 0.
REQ-025 owned_x[i] SHALL be 1 exactly when semaphore i is in OWNx or OWNx_Wy.

Reset
REQ-026 While hresetn = 0, all semaphores SHALL be FREE and all outputs 0 (grant, pending, semerr, owned).
REQ-027 Reset mid-operation SHALL discard all ownership and queued waits; no grant pulse on reset release.

Verification
REQ-028 Core 0 locks id 2 -> next cycle grant_0 = 1, owned_0 = 0x04; core 0 unlocks id 2 -> owned_0 = 0x00.
REQ-029 Core 0 owns id 5; core 1 locks id 5 -> pending_1 = 1. Core 0 unlocks id 5 -> grant_1 = 1, pending_1 = 0, owned_1 = 0x20.
REQ-030 Both cores lock id 0 in the same cycle -> grant_0 = 1, grant_1 = 0, pending_1 = 1, owned_0 = 0x01.
REQ-031 Error pulses: core 1 unlocks id 3 owned by core 0 -> semerr_1 = 0x1 for one cycle; core 0 relocks id 3 -> semerr_0 = 0x2; unlock of free id 4 -> 0x4; req_id = 9 -> 0x8; state unchanged in every case.
REQ-032 Core 0 owns id 1 and core 1 is queued; hresetn asserted -> all outputs 0; after release, core 1 locks id 1 -> immediate grant_1.

Source files
------------

// File: rtl/hsem_lock.sv
// rtl/hsem_lock.sv - two-core hardware semaphore block with one-deep wait queue per semaphore
// Core 0's request is applied first each cycle; core 1's sees the result.
module hsem_lock #(
    parameter int NSEM = 8
) (
    input  logic            hclk,
    input  logic            hresetn,
    input  logic            req_valid_0,
    input  logic            req_op_0,
    input  logic [3:0]      req_id_0,
    input  logic            req_valid_1,
    input  logic            req_op_1,
    input  logic [3:0]      req_id_1,
    output logic            grant_0,
    output logic            grant_1,
    output logic            pending_0,
    output logic            pending_1,
    output logic [31:0]     semerr_0,
    output logic [31:0]     semerr_1,
    output logic [NSEM-1:0] owned_0,
    output logic [NSEM-1:0] owned_1
);

    typedef enum logic [2:0] {
        S_FREE    = 3'd0,
        S_OWN0    = 3'd1,
        S_OWN1    = 3'd2,
        S_OWN0_W1 = 3'd3,
        S_OWN1_W0 = 3'd4
    } sem_state_e;

    typedef struct packed {
        sem_state_e nxt;
        logic [3:0] err;
        logic       gnt_self;
        logic       gnt_other;
    } step_t;

    localparam logic [4:0] NSEM_W = 5'(NSEM);

    sem_state_e      st_q   [NSEM];
    sem_state_e      st_mid [NSEM];
    sem_state_e      st_d   [NSEM];
    step_t           r0, r1;
    logic            gnt0_d, gnt1_d;
    logic [3:0]      err0_d, err1_d;
    logic            pend0_now, pend1_now;
    logic            pend0_d, pend1_d;
    logic [NSEM-1:0] own0_d, own1_d;

    // Outcome of one core's request against one semaphore's current state.
    function automatic step_t apply(input sem_state_e st, input logic core,
                                    input logic lock, input logic pend);
        step_t      r;
        sem_state_e own, own_w, oth, oth_w;
        own   = core ? S_OWN1    : S_OWN0;
        own_w = core ? S_OWN1_W0 : S_OWN0_W1;
        oth   = core ? S_OWN0    : S_OWN1;
        oth_w = core ? S_OWN0_W1 : S_OWN1_W0;
        r.nxt       = st;
        r.err       = 4'b0000;
        r.gnt_self  = 1'b0;
        r.gnt_other = 1'b0;
        if (lock) begin
            if (st == own || st == own_w || st == oth_w || pend) begin
                r.err = 4'b0010;
            end else if (st == S_FREE) begin
                r.nxt      = own;
                r.gnt_self = 1'b1;
            end else begin
                r.nxt = oth_w;
            end
        end else begin
            if (st == S_FREE) begin
                r.err = 4'b0100;
            end else if (st == own) begin
                r.nxt = S_FREE;
            end else if (st == own_w) begin
                r.nxt       = oth;
                r.gnt_other = 1'b1;
            end else if (st == oth_w) begin
                r.nxt = oth;
            end else begin
                r.err = 4'b0001;
            end
        end
        return r;
    endfunction

    always_comb begin
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        err0_d    = 4'b0000;
        err1_d    = 4'b0000;
        r0        = '0;
        r1        = '0;
        pend0_now = 1'b0;
        pend1_now = 1'b0;
        for (int i = 0; i < NSEM; i++) begin
            st_mid[i] = st_q[i];
        end
        for (int i = 0; i < NSEM; i++) begin
            if (st_mid[i] == S_OWN1_W0) pend0_now = 1'b1;
        end
        if (req_valid_0) begin
            if ({1'b0, req_id_0} >= NSEM_W) begin
                err0_d = 4'b1000;
            end else begin
                for (int i = 0; i < NSEM; i++) begin
                    if (4'(i) == req_id_0) begin
                        r0        = apply(st_mid[i], 1'b0, req_op_0, pend0_now);
                        st_mid[i] = r0.nxt;
                        err0_d    = r0.err;
                        gnt0_d    = r0.gnt_self;
                        gnt1_d    = r0.gnt_other;
                    end
                end
            end
        end

        for (int i = 0; i < NSEM; i++) begin
            st_d[i] = st_mid[i];
        end
        for (int i = 0; i < NSEM; i++) begin
            if (st_d[i] == S_OWN0_W1) pend1_now = 1'b1;
        end
        if (req_valid_1) begin
            if ({1'b0, req_id_1} >= NSEM_W) begin
                err1_d = 4'b1000;
            end else begin
                for (int i = 0; i < NSEM; i++) begin
                    if (4'(i) == req_id_1) begin
                        r1      = apply(st_d[i], 1'b1, req_op_1, pend1_now);
                        st_d[i] = r1.nxt;
                        err1_d  = r1.err;
                        gnt1_d  = gnt1_d | r1.gnt_self;
                        gnt0_d  = gnt0_d | r1.gnt_other;
                    end
                end
            end
        end
    end

    always_comb begin
        pend0_d = 1'b0;
        pend1_d = 1'b0;
        own0_d  = '0;
        own1_d  = '0;
        for (int i = 0; i < NSEM; i++) begin
            own0_d[i] = (st_d[i] == S_OWN0) || (st_d[i] == S_OWN0_W1);
            own1_d[i] = (st_d[i] == S_OWN1) || (st_d[i] == S_OWN1_W0);
            if (st_d[i] == S_OWN1_W0) pend0_d = 1'b1;
            if (st_d[i] == S_OWN0_W1) pend1_d = 1'b1;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < NSEM; i++) begin
                st_q[i] <= S_FREE;
            end
            grant_0   <= 1'b0;
            grant_1   <= 1'b0;
            pending_0 <= 1'b0;
            pending_1 <= 1'b0;
            semerr_0  <= 32'd0;
            semerr_1  <= 32'd0;
            owned_0   <= '0;
            owned_1   <= '0;
        end else begin
            for (int i = 0; i < NSEM; i++) begin
                st_q[i] <= st_d[i];
            end
            grant_0   <= gnt0_d;
            grant_1   <= gnt1_d;
            pending_0 <= pend0_d;
            pending_1 <= pend1_d;
            semerr_0  <= {28'd0, err0_d};
            semerr_1  <= {28'd0, err1_d};
            owned_0   <= own0_d;
            owned_1   <= own1_d;
        end
    end

endmodule

// File: tb/tb_hsem_lock.sv
// tb/tb_hsem_lock.sv - randomized and directed checks of hsem_lock against an owner/waiter model
module tb_hsem_lock;
    localparam int NSEM = 8;

    logic            hclk = 1'b0;
    logic            hresetn = 1'b1;
    logic            req_valid_0 = 1'b0, req_op_0 = 1'b0;
    logic [3:0]      req_id_0 = 4'd0;
    logic            req_valid_1 = 1'b0, req_op_1 = 1'b0;
    logic [3:0]      req_id_1 = 4'd0;
    logic            grant_0, grant_1, pending_0, pending_1;
    logic [31:0]     semerr_0, semerr_1;
    logic [NSEM-1:0] owned_0, owned_1;

    hsem_lock #(.NSEM(NSEM)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .req_valid_0(req_valid_0), .req_op_0(req_op_0), .req_id_0(req_id_0),
        .req_valid_1(req_valid_1), .req_op_1(req_op_1), .req_id_1(req_id_1),
        .grant_0(grant_0), .grant_1(grant_1),
        .pending_0(pending_0), .pending_1(pending_1),
        .semerr_0(semerr_0), .semerr_1(semerr_1),
        .owned_0(owned_0), .owned_1(owned_1)
    );

    always #5 hclk = ~hclk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    // Model: owner/waiter per semaphore, -1 meaning nobody.
    int owner  [16];
    int waiter [16];

    logic [1:0]      exp_grant = '0, exp_pend = '0;
    logic [31:0]     exp_err0 = '0, exp_err1 = '0;
    logic [NSEM-1:0] exp_own0 = '0, exp_own1 = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    endtask

    always @(negedge hclk) begin
        if (cmp_en) begin
            chk("grant_0",   32'(grant_0),   32'(exp_grant[0]));
            chk("grant_1",   32'(grant_1),   32'(exp_grant[1]));
            chk("pending_0", 32'(pending_0), 32'(exp_pend[0]));
            chk("pending_1", 32'(pending_1), 32'(exp_pend[1]));
            chk("semerr_0",  semerr_0,       exp_err0);
            chk("semerr_1",  semerr_1,       exp_err1);
            chk("owned_0",   32'(owned_0),   32'(exp_own0));
            chk("owned_1",   32'(owned_1),   32'(exp_own1));
        end
    end

    function automatic bit is_waiting(int c);
        for (int i = 0; i < NSEM; i++) if (waiter[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_req(int c, bit v, bit op, int id,
                                      inout logic [1:0] g, output logic [31:0] e);
        e = 32'd0;
        if (!v) return;
        if (id >= NSEM) begin
            e = 32'h8;
        end else if (op) begin
            if (owner[id] == c || waiter[id] == c || is_waiting(c)) e = 32'h2;
            else if (owner[id] == -1) begin
                owner[id] = c;
                g[c] = 1'b1;
            end else waiter[id] = c;
        end else begin
            if (owner[id] == -1) e = 32'h4;
            else if (owner[id] == c) begin
                if (waiter[id] != -1) begin
                    owner[id]  = waiter[id];
                    g[waiter[id]] = 1'b1;
                    waiter[id] = -1;
                end else owner[id] = -1;
            end else if (waiter[id] == c) waiter[id] = -1;
            else e = 32'h1;
        end
    endfunction

    task automatic cycle(input bit v0, input bit op0, input int id0,
                         input bit v1, input bit op1, input int id1);
        logic [1:0]      g, p;
        logic [31:0]     e0, e1;
        logic [NSEM-1:0] o0, o1;
        req_valid_0 = v0; req_op_0 = op0; req_id_0 = 4'(id0);
        req_valid_1 = v1; req_op_1 = op1; req_id_1 = 4'(id1);
        g = '0;
        model_req(0, v0, op0, id0, g, e0);
        model_req(1, v1, op1, id1, g, e1);
        p  = {is_waiting(1), is_waiting(0)};
        o0 = '0;
        o1 = '0;
        for (int i = 0; i < NSEM; i++) begin
            o0[i] = (owner[i] == 0);
            o1[i] = (owner[i] == 1);
        end
        @(posedge hclk);
        exp_grant = g; exp_pend = p;
        exp_err0 = e0; exp_err1 = e1;
        exp_own0 = o0; exp_own1 = o1;
        #1;
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
    endtask

    task automatic do_reset();
        hresetn = 1'b0;
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            owner[i]  = -1;
            waiter[i] = -1;
        end
        exp_grant = '0; exp_pend = '0;
        exp_err0 = '0; exp_err1 = '0;
        exp_own0 = '0; exp_own1 = '0;
        #1;
        chk("rst_outputs", {grant_0, grant_1, pending_0, pending_1, 28'd0},  32'd0);
        chk("rst_semerr",  semerr_0 | semerr_1, 32'd0);
        chk("rst_owned",   32'(owned_0 | owned_1), 32'd0);
        repeat (2) @(posedge hclk);
        #1;
        hresetn = 1'b1;
    endtask

    initial begin
        int id0, id1;
        #2;
        do_reset();
        cmp_en = 1'b1;

        cycle(1, 1, 2, 0, 0, 0);
        chk("lock2_grant0", 32'(grant_0), 32'd1);
        chk("lock2_owned0", 32'(owned_0), 32'h04);
        cycle(1, 0, 2, 0, 0, 0);
        chk("unlock2_owned0", 32'(owned_0), 32'h00);

        cycle(1, 1, 5, 0, 0, 0);
        cycle(0, 0, 0, 1, 1, 5);
        chk("queue5_pending1", 32'(pending_1), 32'd1);
        cycle(1, 0, 5, 0, 0, 0);
        chk("handoff_grant1",   32'(grant_1),   32'd1);
        chk("handoff_pending1", 32'(pending_1), 32'd0);
        chk("handoff_owned1",   32'(owned_1),   32'h20);

        do_reset();
        cycle(1, 1, 0, 1, 1, 0);
        chk("tie_grant0",   32'(grant_0),   32'd1);
        chk("tie_grant1",   32'(grant_1),   32'd0);
        chk("tie_pending1", 32'(pending_1), 32'd1);
        chk("tie_owned0",   32'(owned_0),   32'h01);

        do_reset();
        cycle(1, 1, 6, 0, 0, 0);
        cycle(1, 0, 6, 1, 1, 6);
        chk("seq_grant1", 32'(grant_1), 32'd1);
        chk("seq_owned1", 32'(owned_1), 32'h40);

        do_reset();
        cycle(1, 1, 3, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 3);
        chk("err_nonowner",  semerr_1, 32'h1);
        cycle(0, 0, 0, 0, 0, 0);
        chk("err_oneshot",   semerr_1, 32'h0);
        cycle(1, 1, 3, 0, 0, 0);
        chk("err_relock",    semerr_0, 32'h2);
        cycle(1, 0, 4, 0, 0, 0);
        chk("err_freeunlk",  semerr_0, 32'h4);
        cycle(1, 1, 9, 0, 0, 0);
        chk("err_badid",     semerr_0, 32'h8);
        chk("err_owned_kept", 32'(owned_0), 32'h08);

        do_reset();
        cycle(1, 1, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 1, 1);
        do_reset();
        cycle(0, 0, 0, 1, 1, 1);
        chk("post_rst_grant1", 32'(grant_1), 32'd1);
        chk("post_rst_owned1", 32'(owned_1), 32'h02);

        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                id0 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
                id1 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
                cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, id0,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, id1);
            end
        end

        @(negedge hclk);
        #1;
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
